// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage data-memory responder. Takes the load/store controls, byte address
// and store data of the instruction in MEM and runs one req/ack transaction
// against a word-wide data memory with variable latency. The pipeline is
// stalled until the access completes. Loads return their data with a one-cycle
// valid pulse. Misaligned word accesses and memory timeouts raise a one-cycle
// bus-error pulse instead.
//
// Ports
//   clk, rst_n        pipeline clock; asynchronous active-low reset
//   in_Mem_Read       load request (held stable while out_Stall=1)
//   in_Mem_Write      store request (held stable while out_Stall=1)
//   in_Store_Byte     store is a byte (SB), otherwise a word (SW)
//   in_Addr           byte address
//   in_Write_Data     store data; SB uses bits [7:0]
//   out_Stall         freeze PC/IF/ID/EXE registers this cycle (combinational)
//   out_Read_Data     load result, held until the next completed load
//   out_Read_Valid    one-cycle pulse: load completed
//   out_Bus_Error     one-cycle pulse: access aborted
//   mem_req .. mem_wdata   registered request side of the memory bus
//   mem_ack, mem_rdata     memory completion and read data
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_Mem_Read,
    input  logic                  in_Mem_Write,
    input  logic                  in_Store_Byte,
    input  logic [ADDR_WIDTH-1:0] in_Addr,
    input  logic [31:0]           in_Write_Data,
    output logic                  out_Stall,
    output logic [31:0]           out_Read_Data,
    output logic                  out_Read_Valid,
    output logic                  out_Bus_Error,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               err_pending;
    logic               read_valid;
    logic               wr_access;
    logic               rd_access;
    logic               misaligned;

    // A store wins over a simultaneous load; the load is simply dropped.
    // Only byte stores may use a non-zero low address; everything else that
    // is not word aligned is rejected without touching memory.
    assign wr_access  = in_Mem_Write;
    assign rd_access  = in_Mem_Read & ~in_Mem_Write;
    assign misaligned = (in_Addr[1:0] != 2'b00) &
                        ((wr_access & ~in_Store_Byte) | rd_access);

    assign out_Read_Valid = read_valid;
    assign out_Bus_Error  = err_pending;

    // Stall is the only combinational output: it has to freeze the front of
    // the pipeline in the very cycle a memory instruction shows up in IDLE.
    // It is forced low while reset is held so nothing upstream stays frozen.
    // DONE never stalls, which lets the finishing instruction leave MEM.
    always_comb begin
        out_Stall = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE:    out_Stall = in_Mem_Read | in_Mem_Write;
                REQ:     out_Stall = 1'b1;
                DONE:    out_Stall = 1'b0;
                default: out_Stall = 1'b0;
            endcase
        end
    end

    // Main controller. IDLE captures the access into the bus registers so
    // mem_req rises one cycle later, REQ waits for mem_ack or the timeout,
    // and DONE is a single cycle that presents the result pulses. The inputs
    // are ignored in DONE because they still belong to the finishing
    // instruction; the following IDLE cycle samples the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            err_pending   <= 1'b0;
            read_valid    <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= 4'h0;
            mem_addr      <= '0;
            mem_wdata     <= 32'h0;
            out_Read_Data <= 32'h0;
        end else begin
            err_pending <= 1'b0;
            read_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_access | rd_access) begin
                        if (misaligned) begin
                            err_pending <= 1'b1;
                            state       <= DONE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_we   <= wr_access;
                            mem_addr <= in_Addr[ADDR_WIDTH-1:2];
                            cnt      <= '0;
                            state    <= REQ;
                            if (wr_access & in_Store_Byte) begin
                                mem_be    <= 4'b0001 << in_Addr[1:0];
                                mem_wdata <= {4{in_Write_Data[7:0]}};
                            end else if (wr_access) begin
                                mem_be    <= 4'hF;
                                mem_wdata <= in_Write_Data;
                            end else begin
                                mem_be    <= 4'hF;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            out_Read_Data <= mem_rdata;
                            read_valid    <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req     <= 1'b0;
                        err_pending <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
